// File: rtl/axi_rd_traffic_gen.sv
// AXI4 read-traffic generator: issues a programmed series of AR bursts with an
// optional inter-burst gap and a cap on outstanding bursts, and checks returning
// R beats for RLAST framing and RRESP errors.
module axi_rd_traffic_gen #(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned ID_WIDTH        = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [7:0]            num_bursts_i,
    input  logic [7:0]            burst_len_i,
    input  logic [7:0]            burst_delay_i,
    input  logic                  burst_incr_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [ADDR_WIDTH-1:0] ar_addr_o,
    output logic [7:0]            ar_len_o,
    output logic [2:0]            ar_size_o,
    output logic [1:0]            ar_burst_o,
    output logic [ID_WIDTH-1:0]   ar_id_o,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic                  r_last_i,
    input  logic [1:0]            r_resp_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  beat_cnt_o,
    output logic [CNT_WIDTH-1:0]  last_err_cnt_o,
    output logic [CNT_WIDTH-1:0]  resp_err_cnt_o
);

    localparam int unsigned BeatBytes = DATA_WIDTH / 8;
    localparam int unsigned SizeLog   = $clog2(BeatBytes);
    localparam int unsigned OutW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StGap,
        StDrain,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_num_left;
    logic [7:0]            r_delay;
    logic [7:0]            r_gap_cnt;
    logic [7:0]            r_beat_idx;
    logic                  r_incr;
    logic [ID_WIDTH-1:0]   r_id;
    logic [OutW-1:0]       r_outstanding;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_last_err_cnt;
    logic [CNT_WIDTH-1:0]  r_resp_err_cnt;

    logic                  w_start;
    logic                  w_ar_hs;
    logic                  w_r_active;
    logic                  w_r_hs;
    logic                  w_r_close;
    logic                  w_last_bad;
    logic [ADDR_WIDTH-1:0] w_addr_step;

    assign w_start     = (r_state == StIdle) && start_i;
    assign ar_valid_o  = (r_state == StIssue) && (r_outstanding < MaxOut);
    assign w_ar_hs     = ar_valid_o && ar_ready_i;
    // R beats outside a run are accepted but never counted.
    assign w_r_active  = (r_state == StIssue) || (r_state == StGap) || (r_state == StDrain);
    assign w_r_hs      = r_valid_i && r_ready_o && w_r_active;
    // Guard against a stray RLAST with nothing outstanding underflowing the counter.
    assign w_r_close   = w_r_hs && r_last_i && (r_outstanding != '0);
    assign w_last_bad  = r_last_i ? (r_beat_idx != r_len) : (r_beat_idx == r_len);
    assign w_addr_step = (ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << SizeLog;

    assign ar_addr_o      = r_addr;
    assign ar_len_o       = r_len;
    assign ar_size_o      = 3'(SizeLog);
    assign ar_burst_o     = 2'b01;
    assign ar_id_o        = r_id;
    assign r_ready_o      = !rst_i;
    assign busy_o         = (r_state != StIdle);
    assign done_o         = (r_state == StDone);
    assign beat_cnt_o     = r_beat_cnt;
    assign last_err_cnt_o = r_last_err_cnt;
    assign resp_err_cnt_o = r_resp_err_cnt;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_next = (num_bursts_i == 8'd0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (w_ar_hs) begin
                    if (r_num_left == 8'd1) begin
                        w_state_next = StDrain;
                    end else if (r_delay != 8'd0) begin
                        w_state_next = StGap;
                    end
                end
            end
            StGap: begin
                if (r_gap_cnt == 8'd1) begin
                    w_state_next = StIssue;
                end
            end
            StDrain: begin
                if (r_outstanding == '0) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Run configuration, burst address and inter-burst gap counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base     <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_num_left <= '0;
            r_delay    <= '0;
            r_incr     <= 1'b0;
            r_id       <= '0;
            r_gap_cnt  <= '0;
        end else if (w_start) begin
            r_base     <= base_addr_i;
            r_addr     <= base_addr_i;
            r_len      <= burst_len_i;
            r_num_left <= num_bursts_i;
            r_delay    <= burst_delay_i;
            r_incr     <= burst_incr_i;
            r_id       <= id_i;
        end else if (w_ar_hs) begin
            r_num_left <= r_num_left - 8'd1;
            r_addr     <= r_incr ? (r_addr + w_addr_step) : r_base;
            r_gap_cnt  <= r_delay;
        end else if (r_state == StGap) begin
            r_gap_cnt  <= r_gap_cnt - 8'd1;
        end
    end

    // Outstanding tracking and R-channel checking with saturating counters.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_outstanding  <= '0;
            r_beat_idx     <= '0;
            r_beat_cnt     <= '0;
            r_last_err_cnt <= '0;
            r_resp_err_cnt <= '0;
        end else if (w_r_active) begin
            if (w_ar_hs && !w_r_close) begin
                r_outstanding <= r_outstanding + OutW'(1);
            end else if (!w_ar_hs && w_r_close) begin
                r_outstanding <= r_outstanding - OutW'(1);
            end
            if (w_r_hs) begin
                if (~&r_beat_cnt) begin
                    r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
                end
                if ((r_resp_i != 2'b00) && (~&r_resp_err_cnt)) begin
                    r_resp_err_cnt <= r_resp_err_cnt + CNT_WIDTH'(1);
                end
                if (w_last_bad && (~&r_last_err_cnt)) begin
                    r_last_err_cnt <= r_last_err_cnt + CNT_WIDTH'(1);
                end
                // A burst closes only on RLAST, however many beats it took.
                if (r_last_i) begin
                    r_beat_idx <= '0;
                end else if (r_beat_idx != 8'hFF) begin
                    r_beat_idx <= r_beat_idx + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_traffic_gen.sv
// Bench for axi_rd_traffic_gen: directed scenarios plus randomized runs, with an
// AR monitor / R responder and expectations derived from the run configuration.
`timescale 1ns/1ps
module tb_axi_rd_traffic_gen;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 8;
    localparam int unsigned MO = 4;
    localparam int unsigned CW = 16;

    logic          clk_i;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [7:0]    num_bursts_i;
    logic [7:0]    burst_len_i;
    logic [7:0]    burst_delay_i;
    logic          burst_incr_i;
    logic [IW-1:0] id_i;
    logic          ar_valid_o;
    logic          ar_ready_i;
    logic [AW-1:0] ar_addr_o;
    logic [7:0]    ar_len_o;
    logic [2:0]    ar_size_o;
    logic [1:0]    ar_burst_o;
    logic [IW-1:0] ar_id_o;
    logic          r_valid_i;
    logic          r_ready_o;
    logic          r_last_i;
    logic [1:0]    r_resp_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] beat_cnt_o;
    logic [CW-1:0] last_err_cnt_o;
    logic [CW-1:0] resp_err_cnt_o;

    axi_rd_traffic_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MAX_OUTSTANDING(MO), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .num_bursts_i(num_bursts_i), .burst_len_i(burst_len_i),
        .burst_delay_i(burst_delay_i), .burst_incr_i(burst_incr_i), .id_i(id_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
        .ar_id_o(ar_id_o), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
        .r_last_i(r_last_i), .r_resp_i(r_resp_i), .busy_o(busy_o), .done_o(done_o),
        .beat_cnt_o(beat_cnt_o), .last_err_cnt_o(last_err_cnt_o),
        .resp_err_cnt_o(resp_err_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Responder knobs.
    bit          drv_en;
    bit          ar_hold;
    int unsigned ar_rdy_pct;
    int unsigned r_pct;
    int unsigned r_err_pct;
    int          r_credit;
    int          trunc_burst;
    int          trunc_at;
    int          err_burst;
    int          err_beat;

    // Observations.
    logic [63:0] ar_log[$];
    int          low_log[$];
    int          pend_len[$];
    int          pend_cyc[$];
    int          pend_no[$];
    int          low_run;
    int          cur_beat;
    int          out_now;
    int          out_max;
    int          stab_viol;
    int          cfg_bad;
    int          done_seen;
    int          exp_resp_err;
    logic [7:0]    exp_len;
    logic [IW-1:0] exp_id;

    logic        prev_valid;
    logic        prev_hs;
    logic [63:0] prev_addr;
    logic [7:0]  prev_len;
    logic        hs;
    int          last_pos;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // AR monitor and R responder; inputs change on the falling edge.
    initial begin
        ar_ready_i = 1'b0; r_valid_i = 1'b0; r_last_i = 1'b0; r_resp_i = 2'b00;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_addr = '0; prev_len = '0;
        forever begin
            @(negedge clk_i);
            if (done_o) done_seen++;
            if (!drv_en) begin
                ar_ready_i = 1'b0; r_valid_i = 1'b0; r_last_i = 1'b0; r_resp_i = 2'b00;
                prev_valid = 1'b0; prev_hs = 1'b0;
            end else begin
                ar_ready_i = !ar_hold && ($urandom_range(0, 99) < ar_rdy_pct);
                if (prev_valid && !prev_hs &&
                    (!ar_valid_o || ar_addr_o !== prev_addr || ar_len_o !== prev_len))
                    stab_viol++;
                hs = ar_valid_o && ar_ready_i;
                if (!ar_valid_o) low_run++;
                if (hs) begin
                    low_log.push_back(low_run);
                    low_run = 0;
                    if (ar_len_o !== exp_len || ar_id_o !== exp_id) cfg_bad++;
                    pend_no.push_back(ar_log.size());
                    ar_log.push_back(ar_addr_o);
                    pend_len.push_back(int'(ar_len_o));
                    pend_cyc.push_back(cyc + 1);
                    out_now++;
                end
                prev_valid = ar_valid_o; prev_addr = ar_addr_o;
                prev_len = ar_len_o; prev_hs = hs;
                r_valid_i = 1'b0; r_last_i = 1'b0; r_resp_i = 2'b00;
                if (r_credit > 0 && pend_len.size() > 0 && pend_cyc[0] <= cyc &&
                    $urandom_range(0, 99) < r_pct) begin
                    last_pos = (pend_no[0] == trunc_burst) ? trunc_at : pend_len[0];
                    r_valid_i = 1'b1;
                    r_last_i = (cur_beat == last_pos);
                    if (pend_no[0] == err_burst && cur_beat == err_beat) r_resp_i = 2'b10;
                    else if ($urandom_range(0, 99) < r_err_pct)
                        r_resp_i = 2'($urandom_range(1, 3));
                    if (r_resp_i != 2'b00) exp_resp_err++;
                    if (r_last_i) begin
                        void'(pend_len.pop_front());
                        void'(pend_cyc.pop_front());
                        void'(pend_no.pop_front());
                        cur_beat = 0;
                        r_credit--;
                        out_now--;
                    end else begin
                        cur_beat++;
                    end
                end
                if (out_now > out_max) out_max = out_now;
            end
        end
    end

    task automatic knobs_default();
        ar_hold = 1'b0; ar_rdy_pct = 100; r_pct = 100; r_err_pct = 0;
        r_credit = 1000000; trunc_burst = -1; trunc_at = 0; err_burst = -1; err_beat = 0;
    endtask

    task automatic start_run(input logic [63:0] base, input int num, input int len,
                             input int delay, input bit incr);
        ar_log.delete(); low_log.delete();
        low_run = 0; out_max = 0; stab_viol = 0; cfg_bad = 0; done_seen = 0;
        exp_resp_err = 0;
        @(negedge clk_i);
        exp_len = 8'(len);
        exp_id = IW'($urandom);
        base_addr_i = base; num_bursts_i = 8'(num); burst_len_i = 8'(len);
        burst_delay_i = 8'(delay); burst_incr_i = incr; id_i = exp_id; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        // Scramble config to show the latched copy is used.
        base_addr_i = {$urandom, $urandom}; num_bursts_i = 8'($urandom);
        burst_len_i = 8'($urandom); burst_delay_i = 8'($urandom);
        burst_incr_i = 1'($urandom); id_i = IW'($urandom);
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int k;
        k = 0;
        while (done_seen == 0 && k < max_cyc) begin
            @(negedge clk_i);
            k++;
        end
        chk(tag, 64'(done_seen != 0), 64'd1);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic check_run(input string tag, input logic [63:0] base, input int num,
                             input int len, input bit incr, input int exp_beats,
                             input int exp_last);
        logic [63:0] ea;
        chk({tag, "_ar_count"}, 64'(ar_log.size()), 64'(num));
        for (int k = 0; k < ar_log.size() && k < num; k++) begin
            ea = incr ? base + 64'(k) * 64'(len + 1) * 64'(DW / 8) : base;
            chk($sformatf("%s_addr%0d", tag, k), ar_log[k], ea);
        end
        chk({tag, "_beats"}, 64'(beat_cnt_o), 64'(exp_beats));
        chk({tag, "_last_err"}, 64'(last_err_cnt_o), 64'(exp_last));
        chk({tag, "_resp_err"}, 64'(resp_err_cnt_o), 64'(exp_resp_err));
        chk({tag, "_done_pulses"}, 64'(done_seen), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
        chk({tag, "_out_cap"}, 64'(out_max <= int'(MO)), 64'd1);
        chk({tag, "_ar_stable"}, 64'(stab_viol), 64'd0);
        chk({tag, "_ar_len_id"}, 64'(cfg_bad), 64'd0);
    endtask

    initial begin
        int len;
        int num;
        int dly;
        bit inc;
        int eb;
        int el;
        int k;
        logic [63:0] base;

        rst_i = 1'b1; drv_en = 1'b0; start_i = 1'b0;
        base_addr_i = '0; num_bursts_i = '0; burst_len_i = '0; burst_delay_i = '0;
        burst_incr_i = 1'b0; id_i = '0;
        knobs_default();
        pend_len.delete(); pend_cyc.delete(); pend_no.delete();
        cur_beat = 0; out_now = 0; exp_len = '0; exp_id = '0;
        repeat (3) @(negedge clk_i);

        // Reset state.
        chk("rst_ar_valid", 64'(ar_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_beats", 64'(beat_cnt_o), 64'd0);
        chk("rst_last_err", 64'(last_err_cnt_o), 64'd0);
        chk("rst_resp_err", 64'(resp_err_cnt_o), 64'd0);
        chk("rst_r_ready", 64'(r_ready_o), 64'd0);
        chk("ar_size", 64'(ar_size_o), 64'd3);
        chk("ar_burst", 64'(ar_burst_o), 64'd1);
        rst_i = 1'b0; drv_en = 1'b1;
        @(negedge clk_i);
        chk("r_ready_after_rst", 64'(r_ready_o), 64'd1);

        // 1: back-to-back incrementing bursts.
        start_run(64'h1000, 4, 3, 0, 1'b1);
        chk("t1_busy", 64'(busy_o), 64'd1);
        wait_done(500, "t1_done");
        check_run("t1", 64'h1000, 4, 3, 1'b1, 16, 0);

        // 2: outstanding cap with R withheld.
        knobs_default();
        r_credit = 0;
        start_run(64'h2000, 8, 1, 0, 1'b1);
        repeat (20) @(negedge clk_i);
        chk("t2_ar_capped", 64'(ar_log.size()), 64'd4);
        chk("t2_valid_low", 64'(ar_valid_o), 64'd0);
        r_credit = 1;
        repeat (12) @(negedge clk_i);
        chk("t2_fifth_ar", 64'(ar_log.size()), 64'd5);
        chk("t2_valid_low2", 64'(ar_valid_o), 64'd0);
        r_credit = 1000000;
        wait_done(500, "t2_done");
        check_run("t2", 64'h2000, 8, 1, 1'b1, 16, 0);
        chk("t2_out_max", 64'(out_max), 64'(MO));

        // 3: inter-burst gap.
        knobs_default();
        start_run(64'h5000, 4, 3, 5, 1'b1);
        wait_done(500, "t3_done");
        check_run("t3", 64'h5000, 4, 3, 1'b1, 16, 0);
        for (int i = 1; i < low_log.size(); i++)
            chk($sformatf("t3_gap%0d", i), 64'(low_log[i]), 64'd5);

        // 4: ARREADY held off, fixed address.
        knobs_default();
        ar_hold = 1'b1;
        start_run(64'h1000, 3, 1, 0, 1'b0);
        repeat (10) @(negedge clk_i);
        chk("t4_valid_held", 64'(ar_valid_o), 64'd1);
        chk("t4_addr_held", ar_addr_o, 64'h1000);
        chk("t4_no_hs", 64'(ar_log.size()), 64'd0);
        ar_hold = 1'b0;
        wait_done(500, "t4_done");
        check_run("t4", 64'h1000, 3, 1, 1'b0, 6, 0);

        // 5: early RLAST in burst 0, SLVERR on a beat of burst 1.
        knobs_default();
        trunc_burst = 0; trunc_at = 1; err_burst = 1; err_beat = 0;
        start_run(64'h3000, 2, 3, 0, 1'b1);
        wait_done(500, "t5_done");
        check_run("t5", 64'h3000, 2, 3, 1'b1, 6, 1);
        chk("t5_resp_err_one", 64'(resp_err_cnt_o), 64'd1);

        // 6: reset mid-run, then an empty run.
        knobs_default();
        r_credit = 1;
        start_run(64'h4000, 8, 3, 0, 1'b1);
        k = 0;
        while ((ar_log.size() < 2 || beat_cnt_o < 4) && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        chk("t6_reached", 64'(k < 200), 64'd1);
        chk("t6_busy_pre", 64'(busy_o), 64'd1);
        rst_i = 1'b1; drv_en = 1'b0; ar_ready_i = 1'b0; r_valid_i = 1'b0;
        @(negedge clk_i);
        chk("t6_ar_valid", 64'(ar_valid_o), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_done", 64'(done_o), 64'd0);
        chk("t6_beats", 64'(beat_cnt_o), 64'd0);
        chk("t6_r_ready", 64'(r_ready_o), 64'd0);
        pend_len.delete(); pend_cyc.delete(); pend_no.delete();
        cur_beat = 0; out_now = 0;
        knobs_default();
        rst_i = 1'b0; drv_en = 1'b1;
        @(negedge clk_i);
        chk("t6_r_ready_up", 64'(r_ready_o), 64'd1);
        chk("t6_idle", 64'(busy_o), 64'd0);
        start_run(64'h6000, 0, 3, 0, 1'b1);
        wait_done(50, "t6_zero_done");
        chk("t6_zero_no_ar", 64'(ar_log.size()), 64'd0);
        chk("t6_zero_pulses", 64'(done_seen), 64'd1);

        // Randomized runs.
        for (int it = 0; it < 8; it++) begin
            knobs_default();
            len = int'($urandom_range(0, 7));
            num = int'($urandom_range(1, 6));
            dly = int'($urandom_range(0, 3));
            inc = 1'($urandom);
            base = (it == 0) ? 64'hFFFF_FFFF_FFFF_FF00 : {$urandom, $urandom};
            ar_rdy_pct = $urandom_range(30, 100);
            r_pct = $urandom_range(30, 100);
            r_err_pct = 20;
            if ($urandom_range(0, 1) == 1) begin
                trunc_burst = int'($urandom_range(0, num - 1));
                trunc_at = int'($urandom_range(0, len));
            end
            eb = num * (len + 1) - ((trunc_burst >= 0) ? (len - trunc_at) : 0);
            el = (trunc_burst >= 0 && trunc_at != len) ? 1 : 0;
            start_run(base, num, len, dly, inc);
            wait_done(3000, $sformatf("rnd%0d_done", it));
            check_run($sformatf("rnd%0d", it), base, num, len, inc, eb, el);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
